// File: rtl/eth_rx_ring_writer.sv
// Byte-stream to ring-of-slots frame writer with DA filter; writes and commit land 1 cycle after the beat.
// No backpressure: the stream is never stalled, so a frame that cannot be stored is dropped and counted.
module eth_rx_ring_writer #(
    parameter int NBUF    = 8,
    parameter int BUF_AW  = 11,
    parameter int MIN_LEN = 14,
    parameter int PW      = $clog2(NBUF) + 1
) (
    input  logic                           rx_clk,
    input  logic                           rst_int,
    input  logic [7:0]                     s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    input  logic [47:0]                    mac_address,
    input  logic                           promiscuous,
    input  logic                           accept_mcast,
    input  logic [PW-1:0]                  rd_ptr,
    output logic                           mem_we,
    output logic [$clog2(NBUF)+BUF_AW-1:0] mem_addr,
    output logic [7:0]                     mem_wdata,
    output logic                           len_we,
    output logic [$clog2(NBUF)-1:0]        len_idx,
    output logic [BUF_AW:0]                len_data,
    output logic [PW-1:0]                  wr_ptr,
    output logic                           ring_full,
    output logic                           rx_busy,
    output logic [15:0]                    cnt_drop_full,
    output logic [15:0]                    cnt_drop_err,
    output logic [15:0]                    cnt_drop_filt
);
    localparam int SW = $clog2(NBUF);
    localparam int CW = BUF_AW + 1;
    localparam int AW = SW + BUF_AW;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DISC} state_t;
    typedef enum logic [1:0] {R_NONE, R_FULL, R_FILT, R_ERR} reason_t;

    state_t            state_q, state_d;
    reason_t           reason_q, reason_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [47:0]       dest_q, dest_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              len_we_q, len_we_d;
    logic [SW-1:0]     len_idx_q, len_idx_d;
    logic [CW-1:0]     len_data_q, len_data_d;
    logic [15:0]       cnt_full_q, cnt_full_d;
    logic [15:0]       cnt_err_q, cnt_err_d;
    logic [15:0]       cnt_filt_q, cnt_filt_d;

    logic              inc_full, inc_err, inc_filt, commit;
    logic [CW-1:0]     bcnt_inc;
    logic [47:0]       dest_shift;
    logic              filt_match;
    logic              long_enough;
    logic [SW-1:0]     slot;

    assign bcnt_inc    = bcnt_q + CW'(1);
    assign dest_shift  = {dest_q[39:0], s_axis_tdata};
    assign filt_match  = (&dest_shift) || (dest_shift == mac_address) ||
                         (accept_mcast && (dest_shift[47:24] == 24'h01005E)) || promiscuous;
    assign long_enough = (bcnt_inc >= CW'(MIN_LEN));
    assign slot        = wr_ptr_q[SW-1:0];
    assign ring_full   = ((wr_ptr_q - rd_ptr) == PW'(NBUF));

    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        bcnt_d      = bcnt_q;
        dest_d      = dest_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        len_we_d    = 1'b0;
        len_idx_d   = len_idx_q;
        len_data_d  = len_data_q;
        inc_full    = 1'b0;
        inc_err     = 1'b0;
        inc_filt    = 1'b0;
        commit      = 1'b0;

        if (s_axis_tvalid) begin
            case (state_q)
                S_IDLE: begin
                    if (ring_full) begin
                        if (s_axis_tlast) begin
                            inc_full = 1'b1;
                        end else begin
                            state_d  = S_DISC;
                            reason_d = R_FULL;
                        end
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {slot, {BUF_AW{1'b0}}};
                        mem_wdata_d = s_axis_tdata;
                        bcnt_d      = CW'(1);
                        dest_d      = dest_shift;
                        // A one-byte frame never reaches the filter, so it can only be a runt.
                        if (s_axis_tlast) inc_err = 1'b1;
                        else              state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {slot, bcnt_q[BUF_AW-1:0]};
                    mem_wdata_d = s_axis_tdata;
                    bcnt_d      = bcnt_inc;
                    dest_d      = dest_shift;
                    if (s_axis_tlast) begin
                        state_d = S_IDLE;
                        if (bcnt_inc == CW'(6) && !filt_match)
                            inc_filt = 1'b1;
                        else if (bcnt_inc == CW'(6) && !s_axis_tuser && long_enough)
                            commit = 1'b1;
                        else
                            inc_err = 1'b1;
                    end else if (bcnt_inc == CW'(6)) begin
                        state_d  = filt_match ? S_BODY : S_DISC;
                        reason_d = R_FILT;
                    end
                end
                S_BODY: begin
                    bcnt_d = bcnt_inc;
                    // bcnt_q already equal to the slot size means this beat would overflow the slot.
                    if (bcnt_q[BUF_AW]) begin
                        if (s_axis_tlast) begin
                            state_d = S_IDLE;
                            inc_err = 1'b1;
                        end else begin
                            state_d  = S_DISC;
                            reason_d = R_ERR;
                        end
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {slot, bcnt_q[BUF_AW-1:0]};
                        mem_wdata_d = s_axis_tdata;
                        if (s_axis_tlast) begin
                            state_d = S_IDLE;
                            if (!s_axis_tuser && long_enough) commit  = 1'b1;
                            else                              inc_err = 1'b1;
                        end
                    end
                end
                S_DISC: begin
                    if (s_axis_tlast) begin
                        state_d = S_IDLE;
                        case (reason_q)
                            R_FULL:  inc_full = 1'b1;
                            R_FILT:  inc_filt = 1'b1;
                            default: inc_err  = 1'b1;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (commit) begin
            len_we_d   = 1'b1;
            len_idx_d  = slot;
            len_data_d = bcnt_inc;
            wr_ptr_d   = wr_ptr_q + PW'(1);
        end

        cnt_full_d = (inc_full && cnt_full_q != 16'hFFFF) ? cnt_full_q + 16'd1 : cnt_full_q;
        cnt_err_d  = (inc_err  && cnt_err_q  != 16'hFFFF) ? cnt_err_q  + 16'd1 : cnt_err_q;
        cnt_filt_d = (inc_filt && cnt_filt_q != 16'hFFFF) ? cnt_filt_q + 16'd1 : cnt_filt_q;
    end

    always_ff @(posedge rx_clk or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= S_IDLE;
            reason_q    <= R_NONE;
            bcnt_q      <= '0;
            dest_q      <= '0;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            len_we_q    <= 1'b0;
            len_idx_q   <= '0;
            len_data_q  <= '0;
            cnt_full_q  <= '0;
            cnt_err_q   <= '0;
            cnt_filt_q  <= '0;
        end else begin
            state_q     <= state_d;
            reason_q    <= reason_d;
            bcnt_q      <= bcnt_d;
            dest_q      <= dest_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            len_we_q    <= len_we_d;
            len_idx_q   <= len_idx_d;
            len_data_q  <= len_data_d;
            cnt_full_q  <= cnt_full_d;
            cnt_err_q   <= cnt_err_d;
            cnt_filt_q  <= cnt_filt_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign len_we        = len_we_q;
    assign len_idx       = len_idx_q;
    assign len_data      = len_data_q;
    assign wr_ptr        = wr_ptr_q;
    assign rx_busy       = (state_q != S_IDLE);
    assign cnt_drop_full = cnt_full_q;
    assign cnt_drop_err  = cnt_err_q;
    assign cnt_drop_filt = cnt_filt_q;
endmodule

// File: tb/tb_eth_rx_ring_writer.sv
// Directed bench for eth_rx_ring_writer: a frame-level vector table plus ring-full, back-to-back and reset sequences.
module tb_eth_rx_ring_writer;
    localparam logic [47:0] MAC   = 48'h230100890702;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] MCAST = 48'h01005E000001;
    localparam logic [47:0] OTHER = 48'h021122334455;

    logic        rx_clk = 1'b0;
    logic        rst_int = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic        promiscuous = 1'b0, accept_mcast = 1'b0;
    logic [3:0]  rd_ptr = '0;
    logic        mem_we, len_we, ring_full, rx_busy;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [2:0]  len_idx;
    logic [11:0] len_data;
    logic [3:0]  wr_ptr;
    logic [15:0] cnt_drop_full, cnt_drop_err, cnt_drop_filt;

    eth_rx_ring_writer dut (
        .rx_clk(rx_clk), .rst_int(rst_int),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .mac_address(MAC), .promiscuous(promiscuous), .accept_mcast(accept_mcast),
        .rd_ptr(rd_ptr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .len_we(len_we), .len_idx(len_idx), .len_data(len_data), .wr_ptr(wr_ptr),
        .ring_full(ring_full), .rx_busy(rx_busy), .cnt_drop_full(cnt_drop_full),
        .cnt_drop_err(cnt_drop_err), .cnt_drop_filt(cnt_drop_filt)
    );

    always #5 rx_clk = ~rx_clk;

    int errors = 0, checks = 0;
    int wr_cnt = 0, commit_cnt = 0, data_bad = 0, exp_off = 0;
    int last_idx = 0, last_len = 0;
    int idx_log[$];
    int off0_log[$];

    function automatic logic [7:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return v[7:0] ^ 8'h5A;
    endfunction

    // Scoreboard: offsets must run 0,1,2.. within a frame; payload bytes follow pat().
    always @(negedge rx_clk) begin
        if (mem_we) begin
            int off;
            off = int'(mem_addr[10:0]);
            wr_cnt++;
            if (off == 0) off0_log.push_back(int'(mem_addr[13:11]));
            else if (off != exp_off) data_bad++;
            if (off >= 6 && mem_wdata != pat(off)) data_bad++;
            exp_off = off + 1;
        end
        if (len_we) begin
            commit_cnt++;
            last_idx = int'(len_idx);
            last_len = int'(len_data);
            idx_log.push_back(int'(len_idx));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic send(input int len, input logic [47:0] dst, input logic tu, input int from, input int to);
        for (int i = from; i < to; i++) begin
            if (i < 6) s_axis_tdata = dst[47-8*i -: 8];
            else       s_axis_tdata = pat(i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = (i == len - 1) ? tu : 1'b0;
            @(posedge rx_clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic do_reset();
        rst_int = 1'b1;
        idle(2);
        rst_int = 1'b0;
        idle(1);
    endtask

    typedef struct {
        int len; logic [47:0] dst; logic tu; logic mc; logic pr;
        int ew; int ec; int eidx; int elen; int ewp; int eerr; int efilt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int w0, c0;
        tbl[0]  = '{64,   MAC,   1'b0, 1'b0, 1'b0, 64,   1, 0, 64,   1, 0, 0};
        tbl[1]  = '{60,   BCAST, 1'b0, 1'b0, 1'b0, 60,   1, 1, 60,   2, 0, 0};
        tbl[2]  = '{64,   MCAST, 1'b0, 1'b0, 1'b0, 6,    0, 0, 0,    2, 0, 1};
        tbl[3]  = '{64,   MCAST, 1'b0, 1'b1, 1'b0, 64,   1, 2, 64,   3, 0, 1};
        tbl[4]  = '{100,  MAC,   1'b1, 1'b0, 1'b0, 100,  0, 0, 0,    3, 1, 1};
        tbl[5]  = '{10,   MAC,   1'b0, 1'b0, 1'b0, 10,   0, 0, 0,    3, 2, 1};
        tbl[6]  = '{2049, MAC,   1'b0, 1'b0, 1'b0, 2048, 0, 0, 0,    3, 3, 1};
        tbl[7]  = '{64,   OTHER, 1'b0, 1'b0, 1'b1, 64,   1, 3, 64,   4, 3, 1};
        tbl[8]  = '{14,   MAC,   1'b0, 1'b0, 1'b0, 14,   1, 4, 14,   5, 3, 1};
        tbl[9]  = '{13,   MAC,   1'b0, 1'b0, 1'b0, 13,   0, 0, 0,    5, 4, 1};
        tbl[10] = '{4,    OTHER, 1'b0, 1'b0, 1'b0, 4,    0, 0, 0,    5, 5, 1};
        tbl[11] = '{2048, MAC,   1'b0, 1'b0, 1'b0, 2048, 1, 5, 2048, 6, 5, 1};
        tbl[12] = '{1,    MAC,   1'b0, 1'b0, 1'b0, 1,    0, 0, 0,    6, 6, 1};
        tbl[13] = '{20,   OTHER, 1'b1, 1'b0, 1'b0, 6,    0, 0, 0,    6, 6, 2};

        idle(2);
        chk("reset_outputs", {mem_we, mem_addr, mem_wdata, len_we, len_idx, len_data, wr_ptr, rx_busy, ring_full}, 64'd0);
        chk("reset_counters", {cnt_drop_full, cnt_drop_err, cnt_drop_filt}, 64'd0);
        rst_int = 1'b0;
        idle(2);

        for (int v = 0; v < 14; v++) begin
            accept_mcast = tbl[v].mc;
            promiscuous  = tbl[v].pr;
            w0 = wr_cnt; c0 = commit_cnt; data_bad = 0;
            send(tbl[v].len, tbl[v].dst, tbl[v].tu, 0, tbl[v].len);
            idle(3);
            chk($sformatf("v%0d_writes", v), wr_cnt - w0, tbl[v].ew);
            chk($sformatf("v%0d_commits", v), commit_cnt - c0, tbl[v].ec);
            if (tbl[v].ec != 0) begin
                chk($sformatf("v%0d_len_idx", v), last_idx, tbl[v].eidx);
                chk($sformatf("v%0d_len_data", v), last_len, tbl[v].elen);
            end
            chk($sformatf("v%0d_wr_ptr", v), wr_ptr, tbl[v].ewp);
            chk($sformatf("v%0d_cnt_err", v), cnt_drop_err, tbl[v].eerr);
            chk($sformatf("v%0d_cnt_filt", v), cnt_drop_filt, tbl[v].efilt);
            chk($sformatf("v%0d_data", v), data_bad, 0);
        end
        chk("tbl_cnt_full", cnt_drop_full, 0);
        accept_mcast = 1'b0;
        promiscuous  = 1'b0;

        // Ring full: eight commits with rd_ptr=0, then drops until the consumer frees a slot.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(20, MAC, 1'b0, 0, 20);
            idle(1);
        end
        idle(2);
        chk("full_wr_ptr", wr_ptr, 8);
        chk("full_flag", ring_full, 1);
        w0 = wr_cnt;
        send(20, MAC, 1'b0, 0, 20);
        idle(3);
        chk("full_no_writes", wr_cnt - w0, 0);
        chk("full_cnt1", cnt_drop_full, 1);
        chk("full_wr_ptr_hold", wr_ptr, 8);
        send(1, MAC, 1'b0, 0, 1);
        idle(2);
        chk("full_single_beat_cnt", cnt_drop_full, 2);
        rd_ptr = 4'd1;
        idle(1);
        chk("full_released", ring_full, 0);
        c0 = commit_cnt;
        send(20, MAC, 1'b0, 0, 20);
        idle(3);
        chk("full_after_commit", commit_cnt - c0, 1);
        chk("full_after_idx", last_idx, 0);
        chk("full_after_wr_ptr", wr_ptr, 9);

        // Back-to-back frames with no idle cycle between them.
        rd_ptr = 4'd0;
        do_reset();
        idx_log.delete();
        off0_log.delete();
        data_bad = 0;
        send(64, MAC, 1'b0, 0, 64);
        send(64, MAC, 1'b0, 0, 64);
        idle(3);
        chk("b2b_commits", idx_log.size(), 2);
        chk("b2b_idx0", (idx_log.size() > 0) ? idx_log[0] : -1, 0);
        chk("b2b_idx1", (idx_log.size() > 1) ? idx_log[1] : -1, 1);
        chk("b2b_slot1_off0", (off0_log.size() > 1) ? off0_log[1] : -1, 1);
        chk("b2b_wr_ptr", wr_ptr, 2);
        chk("b2b_data", data_bad, 0);

        // Reset in the middle of a frame, then the tail arrives as a new frame.
        send(10, MAC, 1'b0, 0, 10);
        idle(2);
        send(64, MAC, 1'b0, 0, 30);
        chk("mid_busy", rx_busy, 1);
        rst_int = 1'b1;
        #2;
        chk("mid_rst_outputs", {mem_we, mem_addr, mem_wdata, len_we, len_idx, len_data, wr_ptr, rx_busy}, 64'd0);
        chk("mid_rst_counters", {cnt_drop_full, cnt_drop_err, cnt_drop_filt}, 64'd0);
        idle(1);
        rst_int = 1'b0;
        idle(1);
        send(64, MAC, 1'b0, 30, 64);
        idle(3);
        chk("mid_tail_filt", cnt_drop_filt, 1);
        chk("mid_tail_wr_ptr", wr_ptr, 0);
        c0 = commit_cnt;
        send(64, MAC, 1'b0, 0, 64);
        idle(3);
        chk("mid_good_commit", commit_cnt - c0, 1);
        chk("mid_good_idx", last_idx, 0);
        chk("mid_good_wr_ptr", wr_ptr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
